// File: rtl/rifl_scramble_cntrl_ml_if.sv
// Beat-level bus between framing/CRC logic and the RIFL scrambler controller.
// Master drives beats in and consumes processed beats; slave is the controller.
interface rifl_scramble_cntrl_ml_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DWIDTH    = 64
);
  logic                          in_valid;
  logic                          sof;
  logic                          bypass;
  logic [NUM_LANES*DWIDTH-1:0]   data_in;
  logic                          out_valid;
  logic                          sof_out;
  logic [NUM_LANES*DWIDTH-1:0]   data_out;
  logic                          frame_err;

  modport master (
    output in_valid, sof, bypass, data_in,
    input  out_valid, sof_out, data_out, frame_err
  );

  modport slave (
    input  in_valid, sof, bypass, data_in,
    output out_valid, sof_out, data_out, frame_err
  );
endinterface

// File: rtl/rifl_scramble_cntrl_ml.sv
// Multi-lane frame-aware multiplicative scrambler/descrambler (x^N2 + x^N1 + 1).
// One shared frame-position tracker; per-lane state carried across frames.
module rifl_scramble_cntrl_ml #(
  parameter int unsigned   FRAME_WIDTH = 256,
  parameter int unsigned   DWIDTH      = 64,
  parameter int unsigned   NUM_LANES   = 4,
  parameter int unsigned   CRC_WIDTH   = 12,
  parameter bit            DIRECTION   = 1'b0,
  parameter int unsigned   N1          = 13,
  parameter int unsigned   N2          = 33,
  parameter logic [N2-1:0] SEED        = '0
) (
  input logic                     clk,
  input logic                     rst_n,
  rifl_scramble_cntrl_ml_if.slave bus_io
);

  localparam int unsigned     P       = FRAME_WIDTH / DWIDTH;
  localparam int unsigned     CntW    = (P > 1) ? $clog2(P) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(P - 1);
  localparam int unsigned     DataW   = NUM_LANES * DWIDTH;

  if (FRAME_WIDTH % DWIDTH != 0) begin : gen_chk_fw
    $error("FRAME_WIDTH must be a multiple of DWIDTH");
  end
  if (int'(N2) > int'(DWIDTH) - 2) begin : gen_chk_n2
    $error("N2 must not exceed DWIDTH-2");
  end
  if (P == 1 && int'(N2) > int'(DWIDTH) - 2 - int'(CRC_WIDTH)) begin : gen_chk_single
    $error("N2 must not exceed DWIDTH-2-CRC_WIDTH for single-beat frames");
  end

  typedef enum logic [0:0] {StIdle, StFrame} state_e;

  state_e                         state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic                           byp_q, byp_d;
  logic [NUM_LANES-1:0][N2-1:0]   st_q, st_d;
  logic [DataW-1:0]               data_q, data_d;
  logic                           valid_q, sof_q, err_q;

  logic                           accept, err, byp_cur, head, tail;
  logic [CntW-1:0]                beat_idx;
  logic [N2+DWIDTH-1:0]           lane_res [NUM_LANES];

  // Returns {next_state, processed_beat}; header and CRC bits do not touch the state.
  function automatic logic [N2+DWIDTH-1:0] lane_proc(input logic [DWIDTH-1:0] b,
                                                     input logic [N2-1:0]     s_in,
                                                     input logic              is_head,
                                                     input logic              is_tail);
    logic [N2-1:0]     s;
    logic [DWIDTH-1:0] o;
    logic              f;
    s = s_in;
    o = b;
    for (int i = int'(DWIDTH) - 1; i >= 0; i--) begin
      if (is_head && i >= int'(DWIDTH) - 2) begin
        o[i] = b[i];
      end else if (is_tail && i < int'(CRC_WIDTH)) begin
        o[i] = 1'b0;
      end else begin
        f    = b[i] ^ s[N1-1] ^ s[N2-1];
        o[i] = f;
        s    = {s[N2-2:0], DIRECTION ? b[i] : f};
      end
    end
    return {s, o};
  endfunction

  // Frame tracker: a sof beat always restarts at index 0, even mid-frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byp_d    = byp_q;
    accept   = 1'b0;
    err      = 1'b0;
    beat_idx = bus_io.sof ? '0 : cnt_q;
    byp_cur  = bus_io.sof ? bus_io.bypass : byp_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          accept = bus_io.sof;
          err    = ~bus_io.sof;
        end
      end
      StFrame: begin
        if (bus_io.in_valid) begin
          accept = 1'b1;
          err    = bus_io.sof;
        end
      end
      default: ;
    endcase
    if (accept) begin
      byp_d = byp_cur;
      if (beat_idx == LastIdx) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        state_d = StFrame;
        cnt_d   = beat_idx + CntW'(1);
      end
    end
  end

  assign head = (beat_idx == '0);
  assign tail = (beat_idx == LastIdx);

  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      lane_res[l] = lane_proc(bus_io.data_in[l*DWIDTH +: DWIDTH], st_q[l], head, tail);
    end
    if (accept) begin
      if (byp_cur) begin
        data_d = bus_io.data_in;
      end else begin
        for (int l = 0; l < int'(NUM_LANES); l++) begin
          data_d[l*DWIDTH +: DWIDTH] = lane_res[l][DWIDTH-1:0];
          st_d[l]                    = lane_res[l][DWIDTH +: N2];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      byp_q   <= 1'b0;
      st_q    <= {NUM_LANES{SEED}};
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byp_q   <= byp_d;
      st_q    <= st_d;
      data_q  <= data_d;
      valid_q <= accept;
      sof_q   <= accept & bus_io.sof;
      err_q   <= err;
    end
  end

  assign bus_io.out_valid = valid_q;
  assign bus_io.sof_out   = sof_q;
  assign bus_io.data_out  = data_q;
  assign bus_io.frame_err = err_q;

endmodule

// File: tb/tb_rifl_scramble_cntrl_ml.sv
// Bench: scrambler feeding a descrambler, checked against a bit-stream model
// every cycle, plus directed literal expectations and an end-to-end scoreboard.
module tb_rifl_scramble_cntrl_ml;
  localparam int DW = 64;
  localparam int NL = 4;
  localparam int FW = 256;
  localparam int CW = 12;
  localparam int N1 = 13;
  localparam int N2 = 33;
  localparam int P  = FW / DW;
  localparam int W  = NL * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rifl_scramble_cntrl_ml_if #(.NUM_LANES(NL), .DWIDTH(DW)) bif1 ();
  rifl_scramble_cntrl_ml_if #(.NUM_LANES(NL), .DWIDTH(DW)) bif2 ();

  // Descrambler samples the bypass that travelled with its sof beat.
  logic byp_dly = 1'b0;
  always @(posedge clk) byp_dly <= bif1.bypass;

  assign bif2.in_valid = bif1.out_valid;
  assign bif2.sof      = bif1.sof_out;
  assign bif2.bypass   = byp_dly;
  assign bif2.data_in  = bif1.data_out;

  rifl_scramble_cntrl_ml #(
    .FRAME_WIDTH(FW), .DWIDTH(DW), .NUM_LANES(NL), .CRC_WIDTH(CW),
    .DIRECTION(1'b0), .N1(N1), .N2(N2), .SEED('0)
  ) dut_tx (
    .clk(clk), .rst_n(rst_n), .bus_io(bif1)
  );

  rifl_scramble_cntrl_ml #(
    .FRAME_WIDTH(FW), .DWIDTH(DW), .NUM_LANES(NL), .CRC_WIDTH(CW),
    .DIRECTION(1'b1), .N1(N1), .N2(N2), .SEED('0)
  ) dut_rx (
    .clk(clk), .rst_n(rst_n), .bus_io(bif2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: frame position as an integer (-1 idle), lane history as a bit queue
  // whose element j is the j-th most recent bit fed back into that lane.
  int            pos   [2];
  bit            mbyp  [2];
  bit            hist  [2*NL][$];
  bit            e_ov  [2];
  bit            e_sof [2];
  bit            e_err [2];
  logic [W-1:0]  e_data[2];
  bit            mb_prev;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pos[k] = -1; mbyp[k] = 1'b0;
      e_ov[k] = 1'b0; e_sof[k] = 1'b0; e_err[k] = 1'b0; e_data[k] = '0;
    end
    for (int q = 0; q < 2*NL; q++) begin
      hist[q].delete();
      repeat (N2) hist[q].push_back(1'b0);
    end
  endtask

  task automatic mstep(input int k, input bit iv, input bit sf, input bit bp,
                       input logic [W-1:0] din);
    int q;
    bit b, o;
    e_ov[k] = 1'b0; e_sof[k] = 1'b0; e_err[k] = 1'b0;
    if (!iv) return;
    if (!sf && pos[k] < 0) begin
      e_err[k] = 1'b1;
      return;
    end
    if (sf) begin
      e_err[k] = (pos[k] >= 0);
      pos[k]   = 0;
      mbyp[k]  = bp;
    end
    e_ov[k] = 1'b1; e_sof[k] = sf;
    for (int l = 0; l < NL; l++) begin
      q = k*NL + l;
      for (int i = DW - 1; i >= 0; i--) begin
        b = din[l*DW + i];
        if (mbyp[k]) o = b;
        else if (pos[k] == 0 && i >= DW - 2) o = b;
        else if (pos[k] == P - 1 && i < CW) o = 1'b0;
        else begin
          o = b ^ hist[q][N1-1] ^ hist[q][N2-1];
          hist[q].push_front(k == 1 ? b : o);
          void'(hist[q].pop_back());
        end
        e_data[k][l*DW + i] = o;
      end
    end
    pos[k] = (pos[k] == P - 1) ? -1 : pos[k] + 1;
  endtask

  initial begin
    model_reset();
    mb_prev = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
        mstep(1, e_ov[0], e_sof[0], mb_prev, e_data[0]);
        mstep(0, bif1.in_valid, bif1.sof, bif1.bypass, bif1.data_in);
      end
      mb_prev = bif1.bypass;
    end
  end

  logic [W-1:0] sb[$];
  bit           lb_on = 1'b0;

  initial begin
    logic [W-1:0] exp_lb;
    forever begin
      @(posedge clk); #2;
      chk("tx_valid", bif1.out_valid, e_ov[0]);
      chk("tx_sof",   bif1.sof_out,   e_sof[0]);
      chk("tx_err",   bif1.frame_err, e_err[0]);
      chk("tx_data",  bif1.data_out,  e_data[0]);
      chk("rx_valid", bif2.out_valid, e_ov[1]);
      chk("rx_sof",   bif2.sof_out,   e_sof[1]);
      chk("rx_err",   bif2.frame_err, e_err[1]);
      chk("rx_data",  bif2.data_out,  e_data[1]);
      if (lb_on && bif2.out_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL loopback_extra: got unexpected beat %h expected none", bif2.data_out);
        end else begin
          exp_lb = sb.pop_front();
          chk("loopback", bif2.data_out, exp_lb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  task automatic drive(input bit iv, input bit sf, input bit bp, input logic [W-1:0] d);
    @(negedge clk);
    bif1.in_valid = iv; bif1.sof = sf; bif1.bypass = bp; bif1.data_in = d;
  endtask

  task automatic settle();
    @(posedge clk); #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bif1.in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [W-1:0] d, a5, e;
    bit           bp;
    a5 = {(W/8){8'hA5}};
    bif1.in_valid = 1'b0; bif1.sof = 1'b0; bif1.bypass = 1'b0; bif1.data_in = '0;

    // Reset state
    settle();
    chk("rst_valid", bif1.out_valid, 1'b0);
    chk("rst_sof",   bif1.sof_out,   1'b0);
    chk("rst_err",   bif1.frame_err, 1'b0);
    chk("rst_data",  bif1.data_out,  '0);
    @(negedge clk); rst_n = 1'b1;

    // All-zero frame, back to back
    for (int b = 0; b < P; b++) begin
      drive(1'b1, b == 0, 1'b0, '0);
      settle();
      chk("zero_valid", bif1.out_valid, 1'b1);
      chk("zero_sof",   bif1.sof_out,   b == 0);
      chk("zero_err",   bif1.frame_err, 1'b0);
      chk("zero_data",  bif1.data_out,  '0);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    settle();
    chk("zero_after_valid", bif1.out_valid, 1'b0);

    // Lane 0 head beat: header 2'b10, bit 61 set
    d = '0; d[63:0] = 64'hA000_0000_0000_0000;
    drive(1'b1, 1'b1, 1'b0, d);
    settle();
    chk("l0_header", bif1.data_out[63:62], 2'b10);
    chk("l0_taps",   {bif1.data_out[61], bif1.data_out[48], bif1.data_out[35]}, 3'b111);
    chk("l0_gap",    bif1.data_out[60:49], 12'h000);
    chk("l0_others", bif1.data_out[W-1:64], '0);
    for (int b = 1; b < P; b++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      settle();
    end

    // Orphan beat while idle
    drive(1'b1, 1'b0, 1'b0, rnd_word());
    settle();
    chk("orphan_valid", bif1.out_valid, 1'b0);
    chk("orphan_err",   bif1.frame_err, 1'b1);
    drive(1'b0, 1'b0, 1'b0, '0);
    settle();
    chk("orphan_err_pulse", bif1.frame_err, 1'b0);

    // sof at index 2 restarts the frame
    drive(1'b1, 1'b1, 1'b0, rnd_word()); settle();
    drive(1'b1, 1'b0, 1'b0, rnd_word()); settle();
    drive(1'b1, 1'b1, 1'b0, rnd_word()); settle();
    chk("midsof_err",   bif1.frame_err, 1'b1);
    chk("midsof_sof",   bif1.sof_out,   1'b1);
    chk("midsof_valid", bif1.out_valid, 1'b1);
    for (int b = 1; b < P; b++) begin
      drive(1'b1, 1'b0, 1'b0, rnd_word()); settle();
      chk("midsof_tail_err", bif1.frame_err, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, rnd_word()); settle();
    chk("midsof_end_orphan", bif1.out_valid, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0); settle();

    // Bypass frame passes everything and holds lane state
    do_reset();
    for (int b = 0; b < P; b++) begin
      drive(1'b1, b == 0, b == 0, a5);
      settle();
      chk("bypass_data", bif1.data_out, a5);
    end
    for (int b = 0; b < P; b++) begin
      drive(1'b1, b == 0, 1'b0, '0);
      settle();
      chk("post_bypass_zero", bif1.data_out, '0);
    end

    // Reset at index 1
    drive(1'b1, 1'b1, 1'b0, rnd_word()); settle();
    drive(1'b1, 1'b0, 1'b0, rnd_word()); settle();
    @(negedge clk);
    bif1.in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bif1.out_valid, 1'b0);
    chk("async_rst_data",  bif1.data_out,  '0);
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, rnd_word()); settle();
    chk("post_rst_orphan", bif1.out_valid, 1'b0);
    for (int b = 0; b < P; b++) begin
      drive(1'b1, b == 0, 1'b0, '0);
      settle();
      chk("post_rst_zero", bif1.data_out, '0);
    end

    // Loopback: random frames, gaps and bypass
    do_reset();
    lb_on = 1'b1;
    for (int f = 0; f < 100; f++) begin
      bp = ($urandom_range(7) == 0);
      for (int b = 0; b < P; b++) begin
        while ($urandom_range(3) == 0) drive(1'b0, 1'b0, 1'($urandom), rnd_word());
        d = rnd_word();
        e = d;
        if (!bp && b == P - 1)
          for (int l = 0; l < NL; l++) e[l*DW +: CW] = '0;
        sb.push_back(e);
        drive(1'b1, b == 0, (b == 0) ? bp : 1'($urandom), d);
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (4) settle();
    chk("loopback_drained", 32'(sb.size()), 32'd0);
    lb_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rifl_scramble_cntrl_ml.md
# rifl_scramble_cntrl_ml

Multi-lane, valid-qualified, frame-aware scrambler/descrambler controller for the RIFL datapath. Each of NUM_LANES lanes carries an independent multiplicative scrambler (x^N2 + x^N1 + 1) and shares one frame-position tracker driven by `sof`/`in_valid`. Within a frame, the 2-bit header passes through in clear, the CRC field is zeroed on the tail beat, and all other bits are scrambled or descrambled. Sits between framing and CRC logic on TX (DIRECTION=0) and between CRC check and deframing on RX (DIRECTION=1); adds stall tolerance, per-frame bypass, async reset and frame-error reporting.

## Interface
- FRAME_WIDTH, 256, frame bits per lane; must be a multiple of DWIDTH
- DWIDTH, 64, bits per lane per beat
- NUM_LANES, 4, independent lanes
- CRC_WIDTH, 12, CRC field width at the LSBs of the tail beat
- DIRECTION, 1'b0, 0 = scramble, 1 = descramble
- N1, 13, inner tap
- N2, 33, scrambler state width (outer tap)
- SEED, {N2{1'b0}}, per-lane state after reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat qualifier for all lanes
- sof  in  1  first beat of a frame; meaningful only with in_valid
- bypass  in  1  sampled on the sof beat; applies to the whole frame
- data_in  in  NUM_LANES*DWIDTH  lane L occupies [L*DWIDTH +: DWIDTH]
- out_valid  out  1  registered in_valid of an accepted beat
- sof_out  out  1  registered sof
- data_out  out  NUM_LANES*DWIDTH  processed data
- frame_err  out  1  one-cycle pulse on a framing violation

## Operation
- P = FRAME_WIDTH/DWIDTH. Beat index `idx` runs 0..P-1 and has an extra IDLE state.
- A beat is accepted when in_valid=1 and either sof=1 or idx≠IDLE.
  - An accepted sof beat has index 0.
  - Each later accepted beat increments idx; after beat P-1, idx goes to IDLE.
- Beat classes:
  - head = index 0: bits [DWIDTH-1:DWIDTH-2] pass through; the remaining bits are processed.
  - tail = index P-1: bits [CRC_WIDTH-1:0] are output as 0; the remaining bits are processed.
  - body = all other beats: all bits are processed.
  - When P=1, one beat is both head and tail: the header passes through, the CRC field is zeroed, and only the middle is processed.
- Per-lane processing, bit by bit, MSB first, over the processed bits only:
  - f = b ^ S[N1-1] ^ S[N2-1]
  - scramble: out = f; S ← {S[N2-2:0], f}
  - descramble: out = f; S ← {S[N2-2:0], b}
  - Lane state S persists across beats and frames, updates only on accepted non-bypass beats, and is never reset by sof.
- Bypass frame:
  - data_out = data_in unchanged, including the header and CRC field.
  - Lane states hold.
  - idx still advances.
- in_valid=0: idx, states and the bypass latch hold; out_valid=0; data_out holds its last value.
- sof with idx∉{IDLE, 0 after wrap} (mid-frame):
  - frame_err pulses.
  - The beat is processed as a new head; idx restarts at 0.
  - bypass is resampled.
- in_valid=1, sof=0, idx=IDLE (orphan beat):
  - The beat is dropped: out_valid=0, no state change.
  - frame_err pulses.
- Illegal configuration, flagged at elaboration with $error: N2 > DWIDTH-2, or (P=1 and N2 > DWIDTH-2-CRC_WIDTH).

## Timing
- Latency is exactly 1 cycle from an accepted beat to out_valid/sof_out/data_out. Throughput is 1 beat/cycle, with no backpressure.
- frame_err is asserted in the same cycle as out_valid for the offending beat (orphan beat: out_valid=0).
- Reset (async assert, released synchronously to the design):
  - out_valid=0, sof_out=0, frame_err=0, data_out=0
  - all lane states = SEED, idx=IDLE, bypass latch=0
- Reset mid-frame aborts the frame. Afterwards, only a sof beat is accepted.
- sof on the beat right after tail (idx=IDLE) is legal and produces no error.

## Test plan
- Config: DWIDTH=64, FRAME_WIDTH=256, NUM_LANES=4, CRC_WIDTH=12, N1=13, N2=33, SEED=0, DIRECTION=0.
- All-zero frame, 4 back-to-back beats with sof on beat 0 → data_out all 0; out_valid high for 4 cycles, 1 cycle delayed; sof_out on the first output; frame_err=0.
- Lane 0 head beat = only bit 61 set, header=2'b10 → lane 0 out: bits 63:62=2'b10; bits 61, 48 and 35 are 1; bits 60..49 are 0; lanes 1-3 all zero.
- Loopback: scrambler instance into descrambler instance (DIRECTION=1), 100 random frames with random in_valid gaps → descrambled output equals the input except tail bits [11:0], which are 0; states match after every frame.
- bypass=1 on sof with 0xA5A5… data → output identical including CRC bits. The next non-bypass frame's output equals the output a fresh run produces with no intervening bypass frame (state held).
- Stimulus error cases:
  - sof at index 2 → frame_err pulse, that beat treated as head.
  - in_valid without sof while IDLE → out_valid=0, frame_err=1 for one cycle.
- rst_n low at index 1 → outputs 0 immediately; after release, a fresh all-zero frame yields all-zero output.
